// File: rtl/mem_stage_param_if.sv
// Bundle between the execute stage and the MEM stage: EX/MEM inputs, WB-facing outputs, stall.
interface mem_stage_param_if #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
);
    logic              reg_write_i;
    logic              reg_store_i;
    logic              mem_write_i;
    logic              mem_read_i;
    logic              byte_mode_i;
    logic              load_sext_i;
    logic              flush_i;
    logic [DATA_W-1:0] pcp2_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] store_data_i;
    logic [RD_W-1:0]   rd_i;

    logic              reg_write_o;
    logic              reg_store_o;
    logic [DATA_W-1:0] pcp2_o;
    logic [DATA_W-1:0] alu_result_o;
    logic [RD_W-1:0]   rd_o;
    logic [DATA_W-1:0] load_data_o;
    logic              load_valid_o;
    logic              stall_o;

    modport slave (
        input  reg_write_i, reg_store_i, mem_write_i, mem_read_i, byte_mode_i,
               load_sext_i, flush_i, pcp2_i, alu_result_i, store_data_i, rd_i,
        output reg_write_o, reg_store_o, pcp2_o, alu_result_o, rd_o,
               load_data_o, load_valid_o, stall_o
    );

    modport master (
        output reg_write_i, reg_store_i, mem_write_i, mem_read_i, byte_mode_i,
               load_sext_i, flush_i, pcp2_i, alu_result_i, store_data_i, rd_i,
        input  reg_write_o, reg_store_o, pcp2_o, alu_result_o, rd_o,
               load_data_o, load_valid_o, stall_o
    );
endinterface

// File: rtl/mem_stage_param.sv
// MEM pipeline stage: EX/MEM register, wait-state data RAM with byte/word access,
// upstream stall and a registered, aligned load result.
module mem_stage_param #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int RD_W        = 3,
    parameter int WAIT_STATES = 0
) (
    input logic              clk,
    input logic              reset,
    mem_stage_param_if.slave bus
);
    localparam int         BYTES = DATA_W / 8;
    localparam int         LSB   = $clog2(BYTES);
    localparam int         OFF_W = (LSB > 0) ? LSB : 1;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic {IDLE, WAIT} state_t;

    logic              reg_write_p0, reg_store_p0, mem_write_p0, mem_read_p0;
    logic              byte_mode_p0, load_sext_p0;
    logic [DATA_W-1:0] pcp2_p0, alu_p0, store_p0;
    logic [RD_W-1:0]   rd_p0;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              stall, complete, access, do_store, do_load;

    logic [ADDR_W-1:0] word;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] ram [2**ADDR_W];

    logic [DATA_W-1:0] load_data_p1;
    logic              vld_p1;

    function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] w,
                                                     input logic [OFF_W-1:0]  o,
                                                     input logic              bm,
                                                     input logic              sx);
        logic signed [7:0] lane;
        if (!bm) return w;
        lane = w[{o, 3'b000} +: 8];
        return sx ? DATA_W'(lane) : DATA_W'($unsigned(lane));
    endfunction

    // ---- stage p0: EX/MEM register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_p0 <= 1'b0;
            reg_store_p0 <= 1'b0;
            mem_write_p0 <= 1'b0;
            mem_read_p0  <= 1'b0;
            byte_mode_p0 <= 1'b0;
            load_sext_p0 <= 1'b0;
            pcp2_p0      <= '0;
            alu_p0       <= '0;
            store_p0     <= '0;
            rd_p0        <= '0;
        end else if (!stall) begin
            // A flushed instruction keeps its data fields but loses every side effect.
            reg_write_p0 <= bus.reg_write_i & ~bus.flush_i;
            reg_store_p0 <= bus.reg_store_i & ~bus.flush_i;
            mem_write_p0 <= bus.mem_write_i & ~bus.flush_i;
            mem_read_p0  <= bus.mem_read_i  & ~bus.flush_i;
            byte_mode_p0 <= bus.byte_mode_i;
            load_sext_p0 <= bus.load_sext_i;
            pcp2_p0      <= bus.pcp2_i;
            alu_p0       <= bus.alu_result_i;
            store_p0     <= bus.store_data_i;
            rd_p0        <= bus.rd_i;
        end
    end

    assign word = alu_p0[ADDR_W+LSB-1:LSB];

    generate
        if (LSB > 0) begin : g_off
            assign off = alu_p0[LSB-1:0];
        end else begin : g_no_off
            assign off = '0;
        end
        if (DATA_W > ADDR_W + LSB) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^alu_p0[DATA_W-1:ADDR_W+LSB];
        end
    endgenerate

    assign access = mem_read_p0 | mem_write_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The access completes in the first cycle with stall low, so the register
    // advances on the same edge that commits the RAM access.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (WS == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        cnt_nxt   = WS;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign do_store = complete & mem_write_p0;
    assign do_load  = complete & mem_read_p0 & ~mem_write_p0;

    // Reset on the completing edge aborts a pending store.
    always_ff @(posedge clk) begin
        if (do_store && !reset) begin
            for (int b = 0; b < BYTES; b++) begin
                if (!byte_mode_p0 || off == OFF_W'(b)) begin
                    ram[word][b*8 +: 8] <= byte_mode_p0 ? store_p0[7:0] : store_p0[b*8 +: 8];
                end
            end
        end
    end

    // ---- stage p1: load result ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1       <= 1'b0;
            load_data_p1 <= '0;
        end else begin
            vld_p1 <= do_load;
            if (do_load) begin
                load_data_p1 <= align_load(ram[word], off, byte_mode_p0, load_sext_p0);
            end
        end
    end

    assign bus.reg_write_o  = reg_write_p0;
    assign bus.reg_store_o  = reg_store_p0;
    assign bus.pcp2_o       = pcp2_p0;
    assign bus.alu_result_o = alu_p0;
    assign bus.rd_o         = rd_p0;
    assign bus.load_data_o  = load_data_p1;
    assign bus.load_valid_o = vld_p1;
    assign bus.stall_o      = stall;
endmodule

// File: tb/tb_mem_stage_param.sv
// Bench for mem_stage_param: four instances with WAIT_STATES 0..3 share one stimulus
// stream; a monitor scores loads of the selected instance against a queue of expectations.
module tb_mem_stage_param;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int RD_W   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              reg_write, reg_store, mem_write, mem_read, byte_mode, load_sext, flush;
    logic [DATA_W-1:0] pcp2, alu_result, store_data;
    logic [RD_W-1:0]   rd;

    logic [3:0]        stall_v, valid_v, rw_v, rs_v;
    logic [DATA_W-1:0] ld_v [4];
    logic [DATA_W-1:0] alu_v [4];
    logic [DATA_W-1:0] pc_v [4];
    logic [RD_W-1:0]   rd_v [4];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            mem_stage_param_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();
            assign bus.reg_write_i  = reg_write;
            assign bus.reg_store_i  = reg_store;
            assign bus.mem_write_i  = mem_write;
            assign bus.mem_read_i   = mem_read;
            assign bus.byte_mode_i  = byte_mode;
            assign bus.load_sext_i  = load_sext;
            assign bus.flush_i      = flush;
            assign bus.pcp2_i       = pcp2;
            assign bus.alu_result_i = alu_result;
            assign bus.store_data_i = store_data;
            assign bus.rd_i         = rd;
            mem_stage_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W), .WAIT_STATES(g)) dut (
                .clk  (clk),
                .reset(reset),
                .bus  (bus)
            );
            assign stall_v[g] = bus.stall_o;
            assign valid_v[g] = bus.load_valid_o;
            assign rw_v[g]    = bus.reg_write_o;
            assign rs_v[g]    = bus.reg_store_o;
            assign ld_v[g]    = bus.load_data_o;
            assign alu_v[g]   = bus.alu_result_o;
            assign pc_v[g]    = bus.pcp2_o;
            assign rd_v[g]    = bus.rd_o;
        end
    endgenerate

    logic [1:0]        sel;
    logic              stall_s, valid_s, rw_s, rs_s;
    logic [DATA_W-1:0] data_s, alu_s, pc_s;
    logic [RD_W-1:0]   rd_s;
    assign stall_s = stall_v[sel];
    assign valid_s = valid_v[sel];
    assign rw_s    = rw_v[sel];
    assign rs_s    = rs_v[sel];
    assign data_s  = ld_v[sel];
    assign alu_s   = alu_v[sel];
    assign pc_s    = pc_v[sel];
    assign rd_s    = rd_v[sel];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;
    exp_t exp_q[$];

    int   total = 0;
    int   passed = 0;
    logic stall_log [256];
    logic stall_seen = 1'b0;
    int   alu_hits = 0;
    logic [DATA_W-1:0] cur_alu = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Monitor: logs stall per cycle and scores every load_valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            stall_log[cyc[7:0]] = stall_s;
            if (stall_s) stall_seen = 1'b1;
            if (alu_s == 16'h0123) alu_hits++;
            if (valid_s) begin
                if (exp_q.size() == 0) begin
                    check("load_valid_unexpected", {31'b0, valid_s}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("load_data", 32'(data_s), 32'(e.data));
                    check("load_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic drive(input logic rw, input logic rs, input logic mw, input logic mr,
                         input logic bm, input logic sx, input logic fl,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] sd);
        reg_write  = rw;
        reg_store  = rs;
        mem_write  = mw;
        mem_read   = mr;
        byte_mode  = bm;
        load_sext  = sx;
        flush      = fl;
        alu_result = alu;
        store_data = sd;
        pcp2       = alu + 16'h0100;
        rd         = alu[RD_W-1:0];
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        pcp2 = '0;
        rd   = '0;
    endtask

    // Called just after a rising edge; returns just after the edge that captured the op.
    task automatic send(input logic rw, input logic rs, input logic mw, input logic mr,
                        input logic bm, input logic sx, input logic fl,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] sd);
        logic s;
        int   n;
        n = 0;
        drive(rw, rs, mw, mr, bm, sx, fl, alu, sd);
        do begin
            @(negedge clk);
            s = stall_s;
            if (s) check("held_alu_result", 32'(alu_s), 32'(cur_alu));
            @(posedge clk);
            #1;
            n++;
        end while (s && n < 40);
        if (s) check("stall_released", {31'b0, s}, 32'd0);
        cur_alu = alu;
        bubble();
    endtask

    task automatic st_word(input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] d);
        send(0, 0, 1, 0, 0, 0, 0, addr, d);
    endtask

    task automatic st_byte(input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] d);
        send(0, 0, 1, 0, 1, 0, 0, addr, d);
    endtask

    task automatic ld(input logic [DATA_W-1:0] addr, input logic bm, input logic sx,
                      input logic [DATA_W-1:0] exp);
        exp_t e;
        send(1, 1, 0, 1, bm, sx, 0, addr, 16'h0000);
        e.data = exp;
        e.due  = cyc + 1 + int'(sel);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        cur_alu = '0;
    endtask

    function automatic logic [7:0] stall_pat(input int c0, input int n);
        logic [7:0] p;
        p = '0;
        for (int k = 0; k < n; k++) p = {p[6:0], stall_log[8'(c0 + k)]};
        return p;
    endfunction

    initial begin
        int c0;
        sel = 2'd0;
        bubble();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("reset_reg_write", {31'b0, rw_s}, 32'd0);
        check("reset_reg_store", {31'b0, rs_s}, 32'd0);
        check("reset_pcp2", 32'(pc_s), 32'd0);
        check("reset_alu_result", 32'(alu_s), 32'd0);
        check("reset_rd", 32'(rd_s), 32'd0);
        check("reset_load_data", 32'(data_s), 32'd0);
        check("reset_load_valid", {31'b0, valid_s}, 32'd0);
        check("reset_stall", {31'b0, stall_s}, 32'd0);
        @(posedge clk);
        #1;

        // WAIT_STATES = 0: word and byte accesses, read-after-write.
        stall_seen = 1'b0;
        st_word(16'h0010, 16'hBEEF);
        ld(16'h0010, 0, 0, 16'hBEEF);
        st_byte(16'h0011, 16'h0080);
        ld(16'h0011, 1, 1, 16'hFF80);
        ld(16'h0011, 1, 0, 16'h0080);
        ld(16'h0010, 0, 0, 16'h80EF);
        ld(16'h0010, 1, 1, 16'hFFEF);

        // Flushed store must leave RAM alone but still carry its data fields.
        st_word(16'h0020, 16'h1111);
        send(1, 0, 1, 0, 0, 0, 1, 16'h0020, 16'h1234);
        @(negedge clk);
        check("flush_reg_write", {31'b0, rw_s}, 32'd0);
        check("flush_stall", {31'b0, stall_s}, 32'd0);
        check("flush_alu_result", 32'(alu_s), 32'h0020);
        check("flush_pcp2", 32'(pc_s), 32'h0120);
        @(posedge clk);
        #1;
        ld(16'h0020, 0, 0, 16'h1111);
        idle(3);
        check("ws0_no_stall", {31'b0, stall_seen}, 32'd0);
        check("ws0_queue_drained", exp_q.size(), 0);

        // WAIT_STATES = 3: three stall cycles, outputs held, then the result.
        rst_pulse();
        sel = 2'd3;
        st_word(16'h0040, 16'h1357);
        ld(16'h0040, 0, 0, 16'h1357);
        c0 = cyc;
        send(1, 0, 0, 0, 0, 0, 0, 16'h0777, 16'h0000);
        check("ws3_stall_pattern", 32'(stall_pat(c0, 4)), 32'b1110);
        idle(5);
        check("ws3_queue_drained", exp_q.size(), 0);

        // WAIT_STATES = 2: reset on the completing edge aborts the store.
        rst_pulse();
        sel = 2'd2;
        st_word(16'h0030, 16'h5555);
        st_word(16'h0030, 16'hAAAA);
        c0 = cyc;
        idle(1);
        idle(1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        cur_alu = '0;
        @(negedge clk);
        check("abort_stall", {31'b0, stall_s}, 32'd0);
        check("abort_reg_write", {31'b0, rw_s}, 32'd0);
        check("abort_alu_result", 32'(alu_s), 32'd0);
        check("abort_pcp2", 32'(pc_s), 32'd0);
        check("abort_load_valid", {31'b0, valid_s}, 32'd0);
        check("abort_stall_before", 32'(stall_pat(c0, 2)), 32'b11);
        @(posedge clk);
        #1;
        ld(16'h0030, 0, 0, 16'h5555);
        idle(4);
        check("ws2_queue_drained", exp_q.size(), 0);

        // WAIT_STATES = 1: load, ALU op, load back to back.
        rst_pulse();
        sel = 2'd1;
        st_word(16'h0050, 16'h2468);
        st_word(16'h0052, 16'h3579);
        alu_hits = 0;
        ld(16'h0050, 0, 0, 16'h2468);
        c0 = cyc;
        send(1, 0, 0, 0, 0, 0, 0, 16'h0123, 16'h0000);
        ld(16'h0052, 0, 0, 16'h3579);
        idle(4);
        check("ws1_stall_pattern", 32'(stall_pat(c0, 5)), 32'b10010);
        check("ws1_alu_op_once", alu_hits, 1);
        check("ws1_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", passed, total);
        $fatal(1);
    end
endmodule
